// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
//
// Shares the single framebuffer pixel write port between N_REQ drawing engines
// (background scroller, sprite, obstacle drawer, ...). Arbitration is per pixel
// round-robin with a valid/grant handshake. A requester may hold 'lock' to keep
// the port for up to MAX_BURST consecutive pixels, so that a sprite row can be
// written without interleaving. While nothing is written the port is parked at
// an off-screen coordinate.
//
// Ports:
//   clk_33m        in   pixel-write clock (vga write side)
//   rst            in   synchronous active-high reset
//   req[N_REQ]     in   per-requester pixel valid
//   lock[N_REQ]    in   per-requester burst hold, only meaningful with req
//   req_x/req_y    in   packed coordinates, requester i at [i*COORD_W +: COORD_W]
//   req_palette    in   packed palette index, requester i at [i*PAL_W +: PAL_W]
//   grant[N_REQ]   out  one-hot or zero, from registered state and req only
//   write_en       out  registered, high when write_* carries a real pixel
//   write_x/y      out  registered pixel coordinate (park value when idle)
//   write_palette  out  registered palette index (zero when idle)
//   busy_owner     out  index of the current lock owner, valid while locked
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int                 N_REQ     = 3,
    parameter int                 COORD_W   = 12,
    parameter int                 PAL_W     = 2,
    parameter int                 MAX_BURST = 16,
    parameter logic [COORD_W-1:0] PARK_X    = {COORD_W{1'b1}},
    parameter logic [COORD_W-1:0] PARK_Y    = {COORD_W{1'b1}}
) (
    input  logic                         clk_33m,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             lock,
    input  logic [N_REQ*COORD_W-1:0]     req_x,
    input  logic [N_REQ*COORD_W-1:0]     req_y,
    input  logic [N_REQ*PAL_W-1:0]       req_palette,
    output logic [N_REQ-1:0]             grant,
    output logic                         write_en,
    output logic [COORD_W-1:0]           write_x,
    output logic [COORD_W-1:0]           write_y,
    output logic [PAL_W-1:0]             write_palette,
    output logic [$clog2(N_REQ)-1:0]     busy_owner
);

    localparam int                 IDX_W     = $clog2(N_REQ);
    localparam int                 CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0]   LAST_REQ  = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   ONE_HOT0  = N_REQ'(1);
    // A burst of one pixel is just a normal transfer, so locking is pointless.
    localparam bit                 BURST_EN  = (MAX_BURST > 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Registered state
    state_t             state_r;
    logic [IDX_W-1:0]   last_r;
    logic [IDX_W-1:0]   owner_r;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic               write_en_r;
    logic [COORD_W-1:0] write_x_r;
    logic [COORD_W-1:0] write_y_r;
    logic [PAL_W-1:0]   write_palette_r;

    // Combinational arbitration signals
    logic [2*N_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   rr_off_s;
    int                 rr_sum_s;
    logic [IDX_W-1:0]   rr_win_s;
    logic               rr_any_s;
    logic [N_REQ-1:0]   grant_s;
    logic [IDX_W-1:0]   win_s;
    logic               xfer_s;
    logic               owner_req_s;
    logic               owner_lock_s;
    logic [COORD_W-1:0] sel_x_s;
    logic [COORD_W-1:0] sel_y_s;
    logic [PAL_W-1:0]   sel_pal_s;

    // Round-robin search: rotate req so requester last+1 lands at bit 0, then
    // take the lowest set bit and rotate the offset back to an absolute index.
    always_comb begin
        rot_s    = {req, req} >> (int'(last_r) + 1);
        rr_off_s = IDX_W'(0);
        for (int k = N_REQ - 1; k >= 0; k--) begin
            rr_off_s = rot_s[k] ? IDX_W'(k) : rr_off_s;
        end
        // last+1+off is at most 2*N_REQ-1, so a single wrap is enough.
        rr_sum_s = int'(last_r) + 1 + int'(rr_off_s);
        rr_win_s = (rr_sum_s >= N_REQ) ? IDX_W'(rr_sum_s - N_REQ) : IDX_W'(rr_sum_s);
        rr_any_s = |req;
    end

    // Grant generation: depends only on registered state and req, never on the
    // pixel data, so no path exists from req_x/y/palette to grant.
    always_comb begin
        grant_s      = {N_REQ{1'b0}};
        win_s        = rr_win_s;
        owner_req_s  = req[owner_r];
        owner_lock_s = lock[owner_r];
        case (state_r)
            ST_IDLE: begin
                win_s = rr_win_s;
                if (rr_any_s) begin
                    grant_s = ONE_HOT0 << rr_win_s;
                end else begin
                    grant_s = {N_REQ{1'b0}};
                end
            end
            ST_LOCKED: begin
                // Only the owner can be served; if it pauses, the port stalls
                // for one cycle and the lock is released at the next edge.
                win_s = owner_r;
                if (owner_req_s) begin
                    grant_s = ONE_HOT0 << owner_r;
                end else begin
                    grant_s = {N_REQ{1'b0}};
                end
            end
            default: begin
                win_s   = rr_win_s;
                grant_s = {N_REQ{1'b0}};
            end
        endcase
        xfer_s = |grant_s;
    end

    // Pixel data mux: AND-OR select by the one-hot grant.
    always_comb begin
        sel_x_s   = {COORD_W{1'b0}};
        sel_y_s   = {COORD_W{1'b0}};
        sel_pal_s = {PAL_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_x_s   = sel_x_s   | (req_x[i*COORD_W +: COORD_W]     & {COORD_W{grant_s[i]}});
            sel_y_s   = sel_y_s   | (req_y[i*COORD_W +: COORD_W]     & {COORD_W{grant_s[i]}});
            sel_pal_s = sel_pal_s | (req_palette[i*PAL_W +: PAL_W]   & {PAL_W{grant_s[i]}});
        end
    end

    // Output register: a transfer at this edge becomes visible after it.
    always_ff @(posedge clk_33m) begin
        if (rst) begin
            write_en_r      <= 1'b0;
            write_x_r       <= PARK_X;
            write_y_r       <= PARK_Y;
            write_palette_r <= {PAL_W{1'b0}};
        end else if (xfer_s) begin
            write_en_r      <= 1'b1;
            write_x_r       <= sel_x_s;
            write_y_r       <= sel_y_s;
            write_palette_r <= sel_pal_s;
        end else begin
            write_en_r      <= 1'b0;
            write_x_r       <= PARK_X;
            write_y_r       <= PARK_Y;
            write_palette_r <= {PAL_W{1'b0}};
        end
    end

    // Arbitration FSM: round-robin pointer, burst lock owner and burst count.
    always_ff @(posedge clk_33m) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_r      <= LAST_REQ;
            owner_r     <= IDX_W'(0);
            burst_cnt_r <= CNT_W'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        last_r <= win_s;
                        if (BURST_EN && lock[win_s]) begin
                            state_r     <= ST_LOCKED;
                            owner_r     <= win_s;
                            burst_cnt_r <= CNT_W'(1);
                        end else begin
                            state_r     <= ST_IDLE;
                            burst_cnt_r <= CNT_W'(0);
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        burst_cnt_r <= CNT_W'(0);
                    end
                end
                ST_LOCKED: begin
                    if (!owner_req_s) begin
                        // Owner paused: release, owner goes to the back.
                        state_r     <= ST_IDLE;
                        last_r      <= owner_r;
                        burst_cnt_r <= CNT_W'(0);
                    end else if (!owner_lock_s || (burst_cnt_r + CNT_W'(1) == BURST_MAX)) begin
                        // Final pixel of the burst is still written this edge.
                        state_r     <= ST_IDLE;
                        last_r      <= owner_r;
                        burst_cnt_r <= CNT_W'(0);
                    end else begin
                        state_r     <= ST_LOCKED;
                        last_r      <= owner_r;
                        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    burst_cnt_r <= CNT_W'(0);
                end
            endcase
        end
    end

    assign grant         = grant_s;
    assign write_en      = write_en_r;
    assign write_x       = write_x_r;
    assign write_y       = write_y_r;
    assign write_palette = write_palette_r;
    assign busy_owner    = owner_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_write_arbiter
//
// Self-checking bench for fb_write_arbiter (N_REQ=3, MAX_BURST=4). A
// behavioural model tracks lock/owner/count/last as plain integers and derives
// the expected grant and the expected write port contents each cycle. Directed
// sequences cover round-robin order, single transfer and park, burst limit,
// owner pause and reset mid-burst; a randomized phase then checks the model
// over 10k cycles together with the starvation bound.
// -----------------------------------------------------------------------------
module tb_fb_write_arbiter;

    localparam int N     = 3;
    localparam int CW    = 12;
    localparam int PW    = 2;
    localparam int MB    = 4;
    localparam int BOUND = (N - 1) * MB + N;

    logic                 clk_33m;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0]         lock;
    logic [N*CW-1:0]      req_x;
    logic [N*CW-1:0]      req_y;
    logic [N*PW-1:0]      req_palette;
    logic [N-1:0]         grant;
    logic                 write_en;
    logic [CW-1:0]        write_x;
    logic [CW-1:0]        write_y;
    logic [PW-1:0]        write_palette;
    logic [$clog2(N)-1:0] busy_owner;

    fb_write_arbiter #(
        .N_REQ     (N),
        .COORD_W   (CW),
        .PAL_W     (PW),
        .MAX_BURST (MB),
        .PARK_X    (12'hFFF),
        .PARK_Y    (12'hFFF)
    ) dut (
        .clk_33m       (clk_33m),
        .rst           (rst),
        .req           (req),
        .lock          (lock),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_palette   (req_palette),
        .grant         (grant),
        .write_en      (write_en),
        .write_x       (write_x),
        .write_y       (write_y),
        .write_palette (write_palette),
        .busy_owner    (busy_owner)
    );

    initial clk_33m = 1'b0;
    always #15 clk_33m = ~clk_33m;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_locked;
    int            m_owner;
    int            m_cnt;
    int            m_last;
    logic          m_we;
    logic [CW-1:0] m_x;
    logic [CW-1:0] m_y;
    logic [PW-1:0] m_p;

    int            wait_c [N];
    int            max_wait;
    logic [N-1:0]  pending;

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_last   = N - 1;
        m_we     = 1'b0;
        m_x      = 12'hFFF;
        m_y      = 12'hFFF;
        m_p      = 2'd0;
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_locked) begin
            if (req[m_owner]) g[m_owner] = 1'b1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (req[i]) begin
                    g[i] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    task automatic model_clock(input logic [N-1:0] g);
        int w;
        w = -1;
        for (int i = 0; i < N; i++) if (g[i]) w = i;
        if (w < 0) begin
            m_we = 1'b0;
            m_x  = 12'hFFF;
            m_y  = 12'hFFF;
            m_p  = 2'd0;
            if (m_locked) begin
                m_locked = 1'b0;
                m_last   = m_owner;
                m_cnt    = 0;
            end
        end else begin
            m_we   = 1'b1;
            m_x    = req_x[w*CW +: CW];
            m_y    = req_y[w*CW +: CW];
            m_p    = req_palette[w*PW +: PW];
            m_last = w;
            if (m_locked) begin
                m_cnt++;
                if (!lock[w] || m_cnt == MB) begin
                    m_locked = 1'b0;
                    m_cnt    = 0;
                end
            end else if (lock[w] && MB > 1) begin
                m_locked = 1'b1;
                m_owner  = w;
                m_cnt    = 1;
            end
        end
    endtask

    task automatic set_px(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y,
                          input logic [PW-1:0] p);
        req_x[i*CW +: CW]       = x;
        req_y[i*CW +: CW]       = y;
        req_palette[i*PW +: PW] = p;
    endtask

    // One clock cycle; called at a falling edge with inputs already driven.
    task automatic cycle(input bit use_d, input logic [N-1:0] dexp);
        logic [N-1:0] g;
        #1;
        if (!rst) begin
            g = model_grant();
            check_eq("grant", {29'd0, grant}, {29'd0, g});
            check_eq("grant_without_req", {29'd0, grant & ~req}, 32'd0);
            if (use_d) check_eq("grant_directed", {29'd0, grant}, {29'd0, dexp});
        end else begin
            g = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (!rst && req[i] && !g[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
        pending = rst ? '0 : (req & ~g);
        @(posedge clk_33m);
        #1;
        if (rst) model_reset();
        else model_clock(g);
        check_eq("write_en", {31'd0, write_en}, {31'd0, m_we});
        check_eq("write_x", {20'd0, write_x}, {20'd0, m_x});
        check_eq("write_y", {20'd0, write_y}, {20'd0, m_y});
        check_eq("write_palette", {30'd0, write_palette}, {30'd0, m_p});
        if (m_locked) check_eq("busy_owner", {30'd0, busy_owner}, m_owner);
        @(negedge clk_33m);
    endtask

    initial begin
        rst         = 1'b1;
        req         = '0;
        lock        = '0;
        req_x       = '0;
        req_y       = '0;
        req_palette = '0;
        pending     = '0;
        max_wait    = 0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        model_reset();

        // Reset state
        @(negedge clk_33m);
        cycle(1'b0, 3'b000);
        cycle(1'b0, 3'b000);
        check_eq("reset_write_en", {31'd0, write_en}, 32'd0);
        check_eq("reset_write_x", {20'd0, write_x}, 32'hFFF);
        check_eq("reset_write_y", {20'd0, write_y}, 32'hFFF);
        check_eq("reset_palette", {30'd0, write_palette}, 32'd0);
        check_eq("reset_busy_owner", {30'd0, busy_owner}, 32'd0);
        rst = 1'b0;

        // Round-robin with all requesters active: 0,1,2,0,1,2
        for (int i = 0; i < N; i++) set_px(i, 12'(16 * i + 5), 12'(8 * i + 3), 2'(i + 1));
        req = 3'b111;
        for (int k = 0; k < 6; k++) cycle(1'b1, 3'b001 << (k % 3));
        req = 3'b000;
        cycle(1'b1, 3'b000);

        // Single transfer from requester 1, then park
        set_px(1, 12'd100, 12'd50, 2'd2);
        req = 3'b010;
        cycle(1'b1, 3'b010);
        check_eq("single_we", {31'd0, write_en}, 32'd1);
        check_eq("single_x", {20'd0, write_x}, 32'd100);
        check_eq("single_y", {20'd0, write_y}, 32'd50);
        check_eq("single_pal", {30'd0, write_palette}, 32'd2);
        req = 3'b000;
        cycle(1'b1, 3'b000);
        check_eq("park_we", {31'd0, write_en}, 32'd0);
        check_eq("park_x", {20'd0, write_x}, 32'hFFF);
        check_eq("park_y", {20'd0, write_y}, 32'hFFF);

        // Move pointer to 2, then burst of MAX_BURST by requester 0
        req = 3'b100;
        cycle(1'b1, 3'b100);
        req  = 3'b101;
        lock = 3'b001;
        for (int k = 0; k < MB; k++) cycle(1'b1, 3'b001);
        cycle(1'b1, 3'b100);
        req  = 3'b000;
        lock = 3'b000;
        cycle(1'b1, 3'b000);

        // Locked owner 1 pauses: stall, release, then requester 2 wins
        req  = 3'b010;
        lock = 3'b010;
        cycle(1'b1, 3'b010);
        req = 3'b001;
        cycle(1'b1, 3'b000);
        req  = 3'b101;
        lock = 3'b000;
        cycle(1'b1, 3'b100);
        req = 3'b000;
        cycle(1'b1, 3'b000);

        // Reset in the middle of a burst
        req  = 3'b001;
        lock = 3'b001;
        cycle(1'b1, 3'b001);
        cycle(1'b1, 3'b001);
        rst = 1'b1;
        cycle(1'b0, 3'b000);
        rst = 1'b0;
        check_eq("midburst_rst_we", {31'd0, write_en}, 32'd0);
        check_eq("midburst_rst_x", {20'd0, write_x}, 32'hFFF);
        req  = 3'b111;
        lock = 3'b000;
        cycle(1'b1, 3'b001);
        req = 3'b000;
        cycle(1'b1, 3'b000);

        // Randomized phase
        pending  = '0;
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) begin
                    req[i] = ($urandom_range(0, 9) != 0);
                end else begin
                    req[i] = 1'($urandom_range(0, 1));
                    set_px(i, 12'($urandom), 12'($urandom), 2'($urandom));
                end
                lock[i] = ($urandom_range(0, 3) != 0);
            end
            cycle(1'b0, 3'b000);
        end
        check_eq("starvation_bound", {31'd0, (max_wait <= BOUND)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single framebuffer pixel write port (write_x/write_y/write_palette into vga, clk_33m domain) between N_REQ drawing engines, e.g. background/ground scroller, dinosaur sprite, obstacle drawer.
- Per-pixel round-robin arbitration with a valid/grant handshake and an optional bounded burst lock, so sprite rows can be written contiguously.
- Parks the write port at an off-screen coordinate when idle.

Parameters:
N_REQ, 3, number of requesters (2..8)
COORD_W, 12, coordinate width, matches vga write_x/write_y
PAL_W, 2, palette index width
MAX_BURST, 16, max consecutive transfers one locked owner may make before forced release (>=1)
PARK_X, 12'hFFF, write_x value while no write
PARK_Y, 12'hFFF, write_y value while no write

Ports:
clk_33m  input  1  pixel-write clock, same as vga write side
rst  input  1  synchronous, active-high reset; driven from rst_screen_33m
req  input  N_REQ  per-requester pixel valid
lock  input  N_REQ  per-requester burst hold request, meaningful only with req
req_x  input  N_REQ*COORD_W  packed x, requester i at [i*COORD_W +: COORD_W]
req_y  input  N_REQ*COORD_W  packed y, same packing
req_palette  input  N_REQ*PAL_W  packed palette index
grant  output  N_REQ  one-hot or zero; combinational from registered state and req
write_en  output  1  registered, high when write_x/y/palette carry a real pixel
write_x  output  COORD_W  registered pixel x to vga
write_y  output  COORD_W  registered pixel y to vga
write_palette  output  PAL_W  registered palette index to vga
busy_owner  output  $clog2(N_REQ)  index of current lock owner, valid while locked

Behaviour:
- Transfer: req[i] && grant[i] at a rising edge. Requester must hold req_x/y/palette stable while req[i]=1 and grant[i]=0.
- At most one grant bit high. grant[i] is never high unless req[i]=1.
- Latency 1: the transfer at edge t sets write_en=1 and write_x/y/palette to the requester's values after edge t. With no transfer, write_en=0, write_x=PARK_X, write_y=PARK_Y, write_palette=0.
- Reset values: write_en=0, write_x=PARK_X, write_y=PARK_Y, write_palette=0, state IDLE, last=N_REQ-1 (requester 0 has highest priority), burst_cnt=0, busy_owner=0. Reset mid-burst drops the lock immediately; no write is issued on the reset cycle.
- Round-robin (IDLE): grant the first i with req[i]=1, scanning last+1, last+2, ... modulo N_REQ. On a transfer, last <= winner.
- State IDLE:
  - Transfer by w with lock[w]=1 and MAX_BURST>1 -> LOCKED, owner=w, burst_cnt=1.
  - Otherwise stay IDLE.
- State LOCKED:
  - If req[owner]=1, grant=owner only; all other requesters are blocked.
  - If req[owner]=0, grant=0 for that cycle (a one-cycle stall is allowed), and the state returns to IDLE at the next edge.
  - Each owner transfer increments burst_cnt.
  - Exit to IDLE at the edge when lock[owner]=0 is sampled with req, or when that transfer makes burst_cnt==MAX_BURST.
  - On exit, last=owner, so the owner has lowest priority next.
  - Dropping lock while req=1 still grants that final pixel.
- burst_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST and is 0 in IDLE.
- Simultaneous requests with lock on several requesters: only the winner locks; the others wait.
- No combinational path from req_x/y/palette to grant. No path from inputs to write_* except through the output register.

Test Plan:
- Reset, then req=3'b111, lock=0, constant per-requester coords -> grants in order 0,1,2,0,1,2. write_en high every cycle from 1 cycle after the first grant. write_x matches the granted requester, delayed by 1 cycle.
- Only req[1]=1, x=100, y=50, palette=2 for one transfer -> grant=3'b010. Next cycle write_en=1, write_x=100, write_y=50, write_palette=2. The cycle after: write_en=0, write_x=12'hFFF, write_y=12'hFFF.
- MAX_BURST=4, req[0] with lock held, req[2] high -> grant[0] for exactly 4 consecutive transfers, then grant[2]. grant[0] is not reasserted until requester 2 is served.
- Locked owner 1 drops req for one cycle while req[0]=1 -> grant=0 that cycle, IDLE next, then requester 2 (if requesting) or 0 is granted per round-robin after last=1.
- Assert rst mid-burst (burst_cnt=2) -> next cycle write_en=0, park coords, state IDLE. First grant after reset goes to the lowest-index requester.
- Random req/lock for 10k cycles with scoreboard -> grant one-hot or zero, no grant without req, no starvation beyond (N_REQ-1)*MAX_BURST+N_REQ cycles, each transfer appears exactly once on write_*.
